// File: rtl/seq_pkg.sv
// Shared definitions for the recurrence sequence generator/checker pair.
package seq_pkg;

  typedef enum logic [1:0] {SEED, CHECK, FAIL} seq_chk_state_t;

  localparam logic [31:0] SEQ_SEED0 = 32'd0;
  localparam logic [31:0] SEQ_SEED1 = 32'd1;
  localparam logic [31:0] SEQ_SEED2 = 32'd1;

  function automatic logic [31:0] seed_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEQ_SEED0;
      2'd1:    return SEQ_SEED1;
      default: return SEQ_SEED2;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_checker.sv
// Checks s[n] = s[n-2] + s[n-3] on a qualified sample stream; registered status,
// sticky error flag and saturating sample/error counters.
module seq_checker
  import seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] seq_i,
  output logic             lock_o,
  output logic             err_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] samp_cnt_o,
  output logic             fail_o
);

  localparam logic [CNT_W:0] MAX_ERR_W = (CNT_W+1)'(MAX_ERR);
  localparam logic [CNT_W:0] ONE_W     = (CNT_W+1)'(1);

  seq_chk_state_t   state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [WIDTH-1:0] h0_q, h1_q, h2_q, h0_d, h1_d, h2_d;
  logic             err_q, err_d, sticky_q, sticky_d;
  logic             lock_q, lock_d, fail_q, fail_d;
  logic             samp_inc, err_inc;
  logic [WIDTH-1:0] exp_w;
  logic             mismatch;

  // h2 is the oldest entry; in SEED the expectation comes from the fixed seed table.
  assign exp_w    = (state_q == SEED) ? WIDTH'(seed_of(idx_q)) : (h1_q + h2_q);
  assign mismatch = (seq_i != exp_w);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    h2_d     = h2_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    samp_inc = 1'b0;
    err_inc  = 1'b0;

    if (en_i) begin
      samp_inc = 1'b1;
      h0_d     = seq_i;
      h1_d     = h0_q;
      h2_d     = h1_q;
      if (state_q != FAIL) begin
        if (state_q == SEED) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd2) state_d = CHECK;
        end
        if (mismatch) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          err_inc  = 1'b1;
          if (({1'b0, err_cnt_o} + ONE_W) == MAX_ERR_W) state_d = FAIL;
        end
      end
    end

    lock_d = (state_d == CHECK) && !sticky_d;
    fail_d = (state_d == FAIL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEED;
      idx_q    <= 2'd0;
      h0_q     <= '0;
      h1_q     <= '0;
      h2_q     <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      lock_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      h2_q     <= h2_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      lock_q   <= lock_d;
      fail_q   <= fail_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_samp_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (samp_inc),
    .cnt_o (samp_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (err_inc),
    .cnt_o (err_cnt_o)
  );

  assign lock_o       = lock_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;
  assign fail_o       = fail_q;

endmodule

// File: tb/tb_seq_checker.sv
// Randomized and directed bench for seq_checker against a queue-based model;
// a second instance with narrow counters exercises saturation.
module tb_seq_checker;

  localparam int CAP  [2] = '{65535, 7};
  localparam int MAXE [2] = '{8, 7};

  logic        clk = 1'b0;
  logic        reset, en_i;
  logic [31:0] seq_i;

  logic        lock_o [2], err_o [2], sticky_o [2], fail_o [2];
  logic [15:0] err_cnt_a, samp_cnt_a;
  logic [2:0]  err_cnt_b, samp_cnt_b;

  always #5 clk = ~clk;

  seq_checker #(.WIDTH(32), .CNT_W(16), .MAX_ERR(8)) dut_a (
    .clk(clk), .reset(reset), .en_i(en_i), .seq_i(seq_i),
    .lock_o(lock_o[0]), .err_o(err_o[0]), .err_sticky_o(sticky_o[0]),
    .err_cnt_o(err_cnt_a), .samp_cnt_o(samp_cnt_a), .fail_o(fail_o[0])
  );

  seq_checker #(.WIDTH(32), .CNT_W(3), .MAX_ERR(7)) dut_b (
    .clk(clk), .reset(reset), .en_i(en_i), .seq_i(seq_i),
    .lock_o(lock_o[1]), .err_o(err_o[1]), .err_sticky_o(sticky_o[1]),
    .err_cnt_o(err_cnt_b), .samp_cnt_o(samp_cnt_b), .fail_o(fail_o[1])
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  // Model: list of accepted samples since reset, plus per-instance error bookkeeping.
  logic [31:0] hist [$];
  int          m_n;
  int          m_err [2], m_samp [2];
  bit          m_fail [2], m_sticky [2], m_pulse [2];

  function automatic logic [31:0] model_exp();
    if (m_n == 0) return 32'd0;
    if (m_n < 3)  return 32'd1;
    return hist[hist.size()-2] + hist[hist.size()-3];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_n = 0;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_samp[k] = 0;
      m_fail[k] = 1'b0; m_sticky[k] = 1'b0; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_accept(input logic [31:0] v);
    logic [31:0] e;
    e = model_exp();
    for (int k = 0; k < 2; k++) begin
      if (m_samp[k] < CAP[k]) m_samp[k]++;
      m_pulse[k] = !m_fail[k] && (v != e);
      if (m_pulse[k]) begin
        m_sticky[k] = 1'b1;
        if (m_err[k] < CAP[k]) m_err[k]++;
        if (m_err[k] == MAXE[k]) m_fail[k] = 1'b1;
      end
    end
    hist.push_back(v);
    m_n++;
  endtask

  task automatic step(input bit rst, input bit en, input logic [31:0] v);
    reset = rst;
    en_i  = en;
    seq_i = v;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) m_pulse[k] = 1'b0;
      if (en) model_accept(v);
    end
    for (int k = 0; k < 2; k++) begin
      check(k == 0 ? "a_lock" : "b_lock", 64'(lock_o[k]), 64'((m_n >= 3) && !m_sticky[k]));
      check(k == 0 ? "a_err" : "b_err", 64'(err_o[k]), 64'(m_pulse[k]));
      check(k == 0 ? "a_sticky" : "b_sticky", 64'(sticky_o[k]), 64'(m_sticky[k]));
      check(k == 0 ? "a_fail" : "b_fail", 64'(fail_o[k]), 64'(m_fail[k]));
    end
    check("a_errcnt", 64'(err_cnt_a), 64'(m_err[0]));
    check("a_sampcnt", 64'(samp_cnt_a), 64'(m_samp[0]));
    check("b_errcnt", 64'(err_cnt_b), 64'(m_err[1]));
    check("b_sampcnt", 64'(samp_cnt_b), 64'(m_samp[1]));
    reset = 1'b0;
    en_i  = 1'b0;
  endtask

  logic [31:0] good [12];
  logic [31:0] bad  [12];

  initial begin
    reset = 1'b1; en_i = 1'b0; seq_i = '0;
    model_reset();
    good = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd9, 32'd12};
    bad[0] = 0; bad[1] = 1; bad[2] = 1;
    for (int n = 3; n < 12; n++) bad[n] = (n == 6) ? 32'd6 : bad[n-2] + bad[n-3];

    phase = "reset";
    step(1, 0, 0);
    step(1, 0, 0);

    phase = "clean";
    for (int n = 0; n < 12; n++) step(0, 1, good[n]);
    check("lock", 64'(lock_o[0]), 64'd1);
    check("samp12", 64'(samp_cnt_a), 64'd12);
    check("err0", 64'(err_cnt_a), 64'd0);

    phase = "corrupt";
    step(1, 0, 0);
    for (int n = 0; n < 12; n++) step(0, 1, bad[n]);
    check("err1", 64'(err_cnt_a), 64'd1);
    check("sticky", 64'(sticky_o[0]), 64'd1);

    phase = "gaps";
    step(1, 0, 0);
    for (int n = 0; n < 12; n++) begin
      step(0, 1, good[n]);
      step(0, 0, $urandom);
    end
    check("samp12", 64'(samp_cnt_a), 64'd12);
    check("err0", 64'(err_cnt_a), 64'd0);

    phase = "wrap";
    step(1, 0, 0);
    step(0, 1, 32'd0); step(0, 1, 32'd1); step(0, 1, 32'd1);
    for (int n = 0; n < 3; n++) step(0, 1, 32'h8000_0000);
    step(0, 1, 32'h0000_0000);
    check("wrap_noerr", 64'(err_o[0]), 64'd0);
    check("wrap_cnt", 64'(err_cnt_a), 64'd3);

    phase = "fail";
    step(1, 0, 0);
    step(0, 1, 32'd0); step(0, 1, 32'd1); step(0, 1, 32'd1);
    for (int n = 0; n < 9; n++) step(0, 1, model_exp() ^ ($urandom | 32'd1));
    check("fail", 64'(fail_o[0]), 64'd1);
    check("err8", 64'(err_cnt_a), 64'd8);
    check("samp12", 64'(samp_cnt_a), 64'd12);
    check("b_sat", 64'(samp_cnt_b), 64'd7);

    phase = "midreset";
    step(1, 0, 0);
    step(0, 1, 32'd0); step(0, 1, 32'd1); step(0, 1, 32'd1);
    step(0, 1, 32'd99); step(0, 1, 32'd98);
    step(1, 1, 32'd97);
    check("cleared", 64'(err_cnt_a), 64'd0);
    step(0, 1, 32'd0); step(0, 1, 32'd1); step(0, 1, 32'd1);
    check("relock", 64'(lock_o[0]), 64'd1);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      bit          rst, en;
      logic [31:0] v;
      rst = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 3) != 0);
      v   = ($urandom_range(0, 7) == 0) ? $urandom : model_exp();
      step(rst, en, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
